// File: rtl/prefetch_issue_queue_pkg.sv
// Shared defaults and types for the prefetch issue queue and its recently-issued filter.
package prefetch_issue_queue_pkg;

    localparam int unsigned PIQ_DEPTH = 4;   // queue entries (power of 2, >= 2)
    localparam int unsigned PIQ_FILT  = 4;   // recently-issued filter entries (>= 1)
    localparam int unsigned PIQ_AW    = 16;  // address width, matches isb addr
    localparam int unsigned PIQ_DCW   = 16;  // drop_count width

    // What leaves the head of the queue on the coming edge.
    typedef enum logic [1:0] {
        POP_NONE  = 2'd0,
        POP_ISSUE = 2'd1,
        POP_KILL  = 2'd2
    } pop_e;

    // Index width for an n-entry structure; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prefetch_issue_queue_pf_filter.sv
// Small CAM of recently issued prefetch addresses. Insertions replace entries
// round-robin; lookup is combinational against the current (pre-edge) contents.
module pf_filter
    import prefetch_issue_queue_pkg::*;
#(
    parameter int unsigned FILT = PIQ_FILT,
    parameter int unsigned AW   = PIQ_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ins_valid,
    input  logic [AW-1:0] ins_addr,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit
);

    localparam int unsigned PW = idx_w(FILT);

    logic [AW-1:0]   r_addr [FILT];
    logic [FILT-1:0] r_vld;
    logic [PW-1:0]   r_ptr;
    logic            w_hit;

    // Entry storage, valid bits and round-robin replacement pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_ptr <= '0;
        end else if (ins_valid) begin
            r_addr[r_ptr] <= ins_addr;
            r_vld[r_ptr]  <= 1'b1;
            r_ptr         <= (r_ptr == PW'(FILT - 1)) ? '0 : r_ptr + PW'(1);
        end
    end

    // Associative match of the lookup address against every valid entry.
    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < FILT; i++) begin
            if (r_vld[i] && (r_addr[i] == lookup_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign hit = w_hit;

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: buffers isb prefetch candidates, drops duplicates of queued,
// recently issued or concurrently demanded lines, squashes queued lines that demand
// traffic has since covered, and issues survivors in order over valid/ready.
module prefetch_issue_queue
    import prefetch_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = PIQ_DEPTH,
    parameter int unsigned FILT  = PIQ_FILT,
    parameter int unsigned AW    = PIQ_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pf_valid,
    input  logic [AW-1:0]      pf_addr,
    input  logic               dmd_valid,
    input  logic [AW-1:0]      dmd_addr,
    output logic               mem_valid,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ready,
    output logic               full,
    output logic [PIQ_DCW-1:0] drop_count
);

    localparam int unsigned PW = idx_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Queue state
    logic [AW-1:0]      r_entry [DEPTH];
    logic [DEPTH-1:0]   r_kill;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [PIQ_DCW-1:0] r_drop;

    // Combinational control
    logic               w_mem_valid;
    logic               w_full;
    logic [DEPTH-1:0]   w_occ;
    logic [DEPTH-1:0]   w_kset;
    logic [DEPTH-1:0]   w_kill_nxt;
    logic               w_q_hit;
    logic               w_flt_hit;
    logic               w_dmd_hit;
    logic               w_enq;
    logic               w_drop;
    logic               w_pop;
    pop_e               w_pop_kind;
    logic [PW-1:0]      w_off;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_mem_valid = (r_count != '0) && !r_kill[r_head];

    assign mem_valid  = w_mem_valid;
    assign mem_addr   = r_entry[r_head];
    assign full       = w_full;
    assign drop_count = r_drop;

    pf_filter #(
        .FILT (FILT),
        .AW   (AW)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ins_valid   (w_pop_kind == POP_ISSUE),
        .ins_addr    (r_entry[r_head]),
        .lookup_addr (pf_addr),
        .hit         (w_flt_hit)
    );

    // Occupancy mask, duplicate detection against queued entries and demand squash set.
    always_comb begin
        w_occ   = '0;
        w_kset  = '0;
        w_q_hit = 1'b0;
        w_off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Distance from head wraps naturally because DEPTH is a power of 2.
            w_off    = PW'(i) - r_head;
            w_occ[i] = (CW'(w_off) < r_count);
            if (w_occ[i] && (r_entry[i] == pf_addr)) begin
                w_q_hit = 1'b1;
            end
            // A head already presented on the bus is never withdrawn.
            if (w_occ[i] && dmd_valid && (r_entry[i] == dmd_addr) &&
                !((PW'(i) == r_head) && w_mem_valid)) begin
                w_kset[i] = 1'b1;
            end
        end
    end

    // Accept/drop decision, head disposition and next kill vector.
    always_comb begin
        w_dmd_hit = dmd_valid && (dmd_addr == pf_addr);
        w_enq     = pf_valid && !w_full && !w_q_hit && !w_flt_hit && !w_dmd_hit;
        w_drop    = pf_valid && !w_enq;

        w_pop_kind = POP_NONE;
        if (r_count != '0) begin
            if (r_kill[r_head]) begin
                w_pop_kind = POP_KILL;
            end else if (mem_ready) begin
                w_pop_kind = POP_ISSUE;
            end
        end
        w_pop = (w_pop_kind != POP_NONE);

        // A slot being refilled starts live regardless of its previous kill state.
        w_kill_nxt = r_kill | w_kset;
        if (w_enq) begin
            w_kill_nxt[r_tail] = 1'b0;
        end
    end

    // Queue pointers, occupancy count, entry storage and kill bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_kill  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_kill <= w_kill_nxt;
            if (w_enq) begin
                r_entry[r_tail] <= pf_addr;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of rejected candidates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + PIQ_DCW'(1);
        end
    end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Self-checking bench for prefetch_issue_queue: queue-based reference model compared
// every cycle, plus hand-computed literal expectations on directed scenarios.
module tb_prefetch_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FILT  = 4;
    localparam int unsigned AW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          pf_valid;
    logic [AW-1:0] pf_addr;
    logic          dmd_valid;
    logic [AW-1:0] dmd_addr;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          full;
    logic [15:0]   drop_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    prefetch_issue_queue #(
        .DEPTH (DEPTH),
        .FILT  (FILT),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pf_valid   (pf_valid),
        .pf_addr    (pf_addr),
        .dmd_valid  (dmd_valid),
        .dmd_addr   (dmd_addr),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .full       (full),
        .drop_count (drop_count)
    );

    // Reference model: ordered list of pending lines, filter as a ring of issued lines.
    typedef struct {
        logic [AW-1:0] addr;
        bit            kill;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] mflt [FILT];
    bit            mflt_v [FILT];
    int unsigned   mrptr;
    int unsigned   mdrop;
    bit            started = 1'b0;

    function automatic bit m_mv();
        return (mq.size() != 0) && !mq[0].kill;
    endfunction

    function automatic logic [AW-1:0] m_addr();
        return (mq.size() != 0) ? mq[0].addr : '0;
    endfunction

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            for (int i = 0; i < FILT; i++) mflt_v[i] = 1'b0;
            mrptr   = 0;
            mdrop   = 0;
            started = 1'b1;
        end else if (started) begin
            bit   mv, isfull, inq, inf, acc;
            ent_t e;
            mv     = m_mv();
            isfull = m_full();
            inq    = 1'b0;
            inf    = 1'b0;
            acc    = 1'b0;
            if (pf_valid) begin
                foreach (mq[k]) if (mq[k].addr == pf_addr) inq = 1'b1;
                for (int i = 0; i < FILT; i++) if (mflt_v[i] && mflt[i] == pf_addr) inf = 1'b1;
                acc = !isfull && !inq && !inf && !(dmd_valid && dmd_addr == pf_addr);
            end
            if (dmd_valid) begin
                foreach (mq[k]) begin
                    if (mq[k].addr == dmd_addr && !(k == 0 && mv)) begin
                        e = mq[k]; e.kill = 1'b1; mq[k] = e;
                    end
                end
            end
            if (mq.size() != 0) begin
                if (mq[0].kill) begin
                    void'(mq.pop_front());
                end else if (mem_ready) begin
                    mflt[mrptr]   = mq[0].addr;
                    mflt_v[mrptr] = 1'b1;
                    mrptr         = (mrptr + 1) % FILT;
                    void'(mq.pop_front());
                end
            end
            if (acc) begin
                e.addr = pf_addr; e.kill = 1'b0;
                mq.push_back(e);
            end else if (pf_valid && mdrop < 32'hFFFF) begin
                mdrop++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("mem_valid", 32'(mem_valid), 32'(m_mv()));
            if (m_mv()) cmp("mem_addr", 32'(mem_addr), 32'(m_addr()));
            cmp("full", 32'(full), 32'(m_full()));
            cmp("drop_count", 32'(drop_count), 32'(mdrop));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pf(input logic [AW-1:0] a);
        pf_valid = 1'b1;
        pf_addr  = a;
        cyc();
        pf_valid = 1'b0;
        pf_addr  = 'x;
    endtask

    task automatic dmd(input logic [AW-1:0] a);
        dmd_valid = 1'b1;
        dmd_addr  = a;
        cyc();
        dmd_valid = 1'b0;
    endtask

    // Literal check of both DUT and model against a hand-computed value.
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] exp);
        cmp(nm, act, exp);
        cmp({nm, "_model"}, mdl, exp);
    endtask

    initial begin
        reset     = 1'b1;
        pf_valid  = 1'b0;
        pf_addr   = 'x;
        dmd_valid = 1'b0;
        dmd_addr  = '0;
        mem_ready = 1'b0;
        repeat (3) cyc();
        lit("rst_mv",   32'(mem_valid),  32'(m_mv()),   0);
        lit("rst_full", 32'(full),       32'(m_full()), 0);
        lit("rst_drop", 32'(drop_count), 32'(mdrop),    0);

        // 1: single candidate into empty queue, visible one cycle later for one cycle
        reset     = 1'b0;
        mem_ready = 1'b1;
        repeat (6) cyc();
        pf(16'h0010);
        lit("t1_mv",   32'(mem_valid), 32'(m_mv()),   1);
        lit("t1_addr", 32'(mem_addr),  32'(m_addr()), 32'h10);
        cyc();
        lit("t1_mv_after", 32'(mem_valid), 32'(m_mv()), 0);

        // 2: fill under stall, overflow drop, ordered stable issue
        reset = 1'b1; cyc(); reset = 1'b0;
        mem_ready = 1'b0;
        pf(16'h0010); pf(16'h0011); pf(16'h0012);
        lit("t2_full3", 32'(full), 32'(m_full()), 0);
        pf(16'h0013);
        lit("t2_full4", 32'(full), 32'(m_full()), 1);
        pf(16'h0014);
        lit("t2_drop", 32'(drop_count), 32'(mdrop), 1);
        cyc(); cyc();
        lit("t2_stall_mv",   32'(mem_valid), 32'(m_mv()),   1);
        lit("t2_stall_addr", 32'(mem_addr),  32'(m_addr()), 32'h10);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lit("t2_order", 32'(mem_addr), 32'(m_addr()), 32'h10 + 32'(k));
            cyc();
        end
        lit("t2_empty_mv", 32'(mem_valid), 32'(m_mv()),   0);
        lit("t2_empty_fl", 32'(full),      32'(m_full()), 0);

        // 3: recently issued address is filtered
        pf(16'h0011);
        lit("t3_drop", 32'(drop_count), 32'(mdrop), 2);
        lit("t3_mv",   32'(mem_valid),  32'(m_mv()), 0);

        // 4: demand squash of non-head entry; presented head survives
        mem_ready = 1'b0;
        pf(16'h0020); pf(16'h0021);
        lit("t4_addr", 32'(mem_addr), 32'(m_addr()), 32'h20);
        dmd(16'h0021);
        dmd(16'h0020);
        lit("t4_held_mv",   32'(mem_valid), 32'(m_mv()),   1);
        lit("t4_held_addr", 32'(mem_addr),  32'(m_addr()), 32'h20);
        mem_ready = 1'b1;
        cyc();
        lit("t4_killed_mv", 32'(mem_valid), 32'(m_mv()), 0);
        cyc();
        lit("t4_gone_mv", 32'(mem_valid), 32'(m_mv()), 0);
        mem_ready = 1'b0;
        pf(16'h0021);
        lit("t4_reuse_addr", 32'(mem_addr), 32'(m_addr()), 32'h21);
        mem_ready = 1'b1;
        cyc();

        // 5: same-cycle demand match, queued duplicate, killed duplicate
        mem_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0030; dmd_valid = 1'b1; dmd_addr = 16'h0030;
        cyc();
        pf_valid = 1'b0; dmd_valid = 1'b0;
        lit("t5_dmd_drop", 32'(drop_count), 32'(mdrop), 3);
        pf(16'h0031); pf(16'h0031);
        lit("t5_dup_drop", 32'(drop_count), 32'(mdrop), 4);
        pf(16'h0032);
        dmd(16'h0032);
        pf(16'h0032);
        lit("t5_kdup_drop", 32'(drop_count), 32'(mdrop), 5);
        dmd(16'h0031);
        lit("t5_head_mv",   32'(mem_valid), 32'(m_mv()),   1);
        lit("t5_head_addr", 32'(mem_addr),  32'(m_addr()), 32'h31);
        mem_ready = 1'b1;
        cyc(); cyc();
        lit("t5_drained", 32'(mem_valid), 32'(m_mv()), 0);

        // 6: full with head popping drops new candidate; reset discards queue
        mem_ready = 1'b0;
        pf(16'h0040); pf(16'h0041); pf(16'h0042); pf(16'h0043);
        lit("t6_full", 32'(full), 32'(m_full()), 1);
        mem_ready = 1'b1;
        pf(16'h0044);
        lit("t6_drop", 32'(drop_count), 32'(mdrop),    6);
        lit("t6_addr", 32'(mem_addr),   32'(m_addr()), 32'h41);
        lit("t6_nf",   32'(full),       32'(m_full()), 0);
        mem_ready = 1'b0;
        reset = 1'b1;
        cyc();
        lit("t6_rst_mv",   32'(mem_valid),  32'(m_mv()), 0);
        lit("t6_rst_drop", 32'(drop_count), 32'(mdrop),  0);
        reset = 1'b0;

        // Mixed traffic over a narrow address range, checked by the per-cycle compare.
        for (int n = 0; n < 400; n++) begin
            pf_valid  = ($urandom_range(0, 1) == 1);
            pf_addr   = 16'h0050 + 16'($urandom_range(0, 7));
            dmd_valid = ($urandom_range(0, 3) == 0);
            dmd_addr  = 16'h0050 + 16'($urandom_range(0, 7));
            mem_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        pf_valid  = 1'b0;
        dmd_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
